apb_cpu_arbiter: RTL and testbench
==================================

// Module: apb_cpu_arbiter
// PURPOSE
//  Shares one APB master between NUM_REQ CPU cores.
//  Each core drives its APBMASTERENABLE/addr/data into a request port. The arbiter grants the shared
//  APB master round-robin, then holds the grant until the transfer completes or times out.
//  It returns PREADY/PRDATA to the granted core only. Sits between the cpu instances and the APB master.
// PARAMETERS
//  NUM_REQ      2    number of requesting cores (2..4)
//  ADDR_W       8    APB address width (instr[28:21])
//  DATA_W       21   APB data width (instr[20:0])
//  TIMEOUT_CYC  16   max cycles in BUSY waiting for MREADY before abort (>=2)
// PORTS
//  clk        in   1                clock, rising edge
//  RESET      in   1                asynchronous reset, active-high
//  REQ        in   NUM_REQ          per-core transfer request (core APBMASTERENABLE)
//  REQ_WRITE  in   NUM_REQ          per-core direction, 1=write 0=read
//  REQ_ADDR   in   NUM_REQ*ADDR_W   per-core address, core i at [i*ADDR_W +: ADDR_W]
//  REQ_DATA   in   NUM_REQ*DATA_W   per-core write data, core i at [i*DATA_W +: DATA_W]
//  GRANT      out  NUM_REQ          one-hot grant, all-zero when idle
//  REQ_READY  out  NUM_REQ          one-cycle completion pulse to granted core (core CPUPREADY)
//  REQ_ERR    out  NUM_REQ          one-cycle timeout pulse to granted core
//  RDATA      out  DATA_W           read data of last completed transfer (core PRDATA)
//  MENABLE    out  1                enable to shared APB master
//  MWRITE     out  1                direction to APB master
//  MADDR      out  ADDR_W           address to APB master
//  MDATA      out  DATA_W           write data to APB master
//  MREADY     in   1                transfer complete from APB master (PREADY)
//  MRDATA     in   DATA_W           read data from APB master (PRDATA)
// BEHAVIOUR
//  Reset (async, RESET=1): state=IDLE; every output 0; cnt=0.
//   last_grant=NUM_REQ-1, so core 0 has top priority first.
//   Reset mid-transfer drops MENABLE/GRANT at once; no REQ_READY or REQ_ERR pulse.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - If REQ!=0, pick the first requesting core g scanning last_grant+1, +2, ... (mod NUM_REQ).
//   - At the next edge: GRANT[g]=1, MENABLE=1, and MWRITE/MADDR/MDATA latch core g's fields.
//   - last_grant<=g; cnt<=0; go to BUSY. Latency from REQ to MENABLE is 1 cycle.
//   - Otherwise stay in IDLE.
//  BUSY:
//   - MADDR/MDATA/MWRITE stay stable; later changes on REQ_* are ignored.
//   - Dropping REQ[g] does not abort the transfer.
//   - MREADY=1 at an edge: MENABLE<=0; REQ_READY[g]<=1 for one cycle; go to DONE.
//     RDATA<=MRDATA when MWRITE=0; RDATA holds its value on writes.
//   - Otherwise cnt<=cnt+1.
//   - When cnt==TIMEOUT_CYC-1 with no MREADY: MENABLE<=0; REQ_ERR[g]<=1 for one cycle;
//     RDATA unchanged; go to DONE.
//   - MREADY on the same edge as the timeout: completion wins and there is no ERR.
//  DONE: exactly one cycle. GRANT is still set; REQ_READY/REQ_ERR visible.
//   At the exit edge GRANT<=0 and the state returns to IDLE.
//   A core re-requesting right away competes under round-robin.
//   Back-to-back transfers therefore occur every 3+ cycles (IDLE, BUSY, DONE).
//  Invariants:
//   - GRANT is one-hot or zero.
//   - MENABLE=1 only in BUSY.
//   - REQ_READY|REQ_ERR is nonzero only in DONE and only on bit g.
//  MREADY in IDLE/DONE is ignored. cnt width is $clog2(TIMEOUT_CYC)+1 and never wraps.
// TESTING
//  1. Reset, REQ=01, core0 addr=8'h01 data=21'h3, MREADY 3 cyc after MENABLE.
//     -> GRANT=01 one cycle after REQ; MADDR=01, MDATA=3 held; REQ_READY[0] one pulse; GRANT=0 after DONE.
//  2. REQ=11 held continuously, MREADY=1 each BUSY cycle.
//     -> grants alternate 01,10,01,10; no core is granted twice in a row.
//  3. Core1 read: MWRITE=0, MRDATA=21'h1F on the MREADY edge.
//     -> RDATA=1F, REQ_READY=10; a following write leaves RDATA=1F.
//  4. MREADY held 0, TIMEOUT_CYC=16.
//     -> MENABLE high for exactly 16 cycles; REQ_ERR[g] pulses once; REQ_READY stays 0.
//  5. RESET asserted 2 cycles into BUSY.
//     -> MENABLE and GRANT go 0 asynchronously; no pulses; after release core0 wins first.
//  6. MREADY arrives on the timeout edge, and core0's REQ_ADDR changes during BUSY.
//     -> REQ_READY pulses, no REQ_ERR; MADDR keeps the latched value.

Source files
------------

// File: rtl/apb_cpu_arbiter.sv
// Round-robin arbiter that shares one APB master between NUM_REQ CPU cores.
// It holds the grant until the transfer completes or times out, then spends one DONE cycle.
module apb_cpu_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 21,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ-1:0]          REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]          GRANT,
  output logic [NUM_REQ-1:0]          REQ_READY,
  output logic [NUM_REQ-1:0]          REQ_ERR,
  output logic [DATA_W-1:0]           RDATA,
  output logic                        MENABLE,
  output logic                        MWRITE,
  output logic [ADDR_W-1:0]           MADDR,
  output logic [DATA_W-1:0]           MDATA,
  input  logic                        MREADY,
  input  logic [DATA_W-1:0]           MRDATA
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 menable_q, menable_d;
  logic                 mwrite_q, mwrite_d;
  logic [ADDR_W-1:0]    maddr_q, maddr_d;
  logic [DATA_W-1:0]    mdata_q, mdata_d;

  logic [ADDR_W-1:0]    req_addr_a [NUM_REQ];
  logic [DATA_W-1:0]    req_data_a [NUM_REQ];
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  // Split the flattened per-core buses into arrays.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_addr_a[i] = REQ_ADDR[i*ADDR_W +: ADDR_W];
      req_data_a[i] = REQ_DATA[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: first requester after last_grant, wrapping around.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    ready_d      = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    menable_d    = menable_q;
    mwrite_d     = mwrite_q;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d      = NUM_REQ'(1) << pick_idx;
          menable_d    = 1'b1;
          mwrite_d     = REQ_WRITE[pick_idx];
          maddr_d      = req_addr_a[pick_idx];
          mdata_d      = req_data_a[pick_idx];
          last_grant_d = pick_idx;
          cnt_d        = '0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Completion takes priority over a coincident timeout.
        if (MREADY) begin
          menable_d = 1'b0;
          ready_d   = grant_q;
          if (!mwrite_q) rdata_d = MRDATA;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          menable_d = 1'b0;
          err_d     = grant_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d   = '0;
        menable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      grant_q      <= '0;
      ready_q      <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      menable_q    <= 1'b0;
      mwrite_q     <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      menable_q    <= menable_d;
      mwrite_q     <= mwrite_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
    end
  end

  assign GRANT     = grant_q;
  assign REQ_READY = ready_q;
  assign REQ_ERR   = err_q;
  assign RDATA     = rdata_q;
  assign MENABLE   = menable_q;
  assign MWRITE    = mwrite_q;
  assign MADDR     = maddr_q;
  assign MDATA     = mdata_q;

endmodule

// File: tb/tb_apb_cpu_arbiter.sv
// Bench for apb_cpu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the shared-master protocol.
module tb_apb_cpu_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 21;
  localparam int TIMEOUT_CYC = 16;

  logic                      clk;
  logic                      RESET;
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ-1:0]        REQ_WRITE;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]        GRANT;
  logic [NUM_REQ-1:0]        REQ_READY;
  logic [NUM_REQ-1:0]        REQ_ERR;
  logic [DATA_W-1:0]         RDATA;
  logic                      MENABLE;
  logic                      MWRITE;
  logic [ADDR_W-1:0]         MADDR;
  logic [DATA_W-1:0]         MDATA;
  logic                      MREADY;
  logic [DATA_W-1:0]         MRDATA;

  apb_cpu_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .RESET(RESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .GRANT(GRANT), .REQ_READY(REQ_READY), .REQ_ERR(REQ_ERR),
    .RDATA(RDATA), .MENABLE(MENABLE), .MWRITE(MWRITE), .MADDR(MADDR), .MDATA(MDATA),
    .MREADY(MREADY), .MRDATA(MRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus, how long the transfer has run, what was latched.
  int          m_owner;
  bit          m_inflight;
  bit          m_done;
  int          m_last;
  int          m_elapsed;
  bit          m_write;
  int unsigned m_addr, m_data, m_rdata;
  int unsigned m_ready, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_inflight = 0; m_done = 0; m_last = NUM_REQ - 1; m_elapsed = 0;
    m_write = 0; m_addr = 0; m_data = 0; m_rdata = 0; m_ready = 0; m_err = 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented before that edge.
  function automatic void model_step();
    int c;
    m_ready = 0;
    m_err   = 0;
    if (m_done) begin
      m_done  = 0;
      m_owner = -1;
    end else if (m_inflight) begin
      if (MREADY) begin
        m_inflight = 0; m_done = 1; m_ready = 1 << m_owner;
        if (!m_write) m_rdata = MRDATA;
      end else if (m_elapsed == TIMEOUT_CYC - 1) begin
        m_inflight = 0; m_done = 1; m_err = 1 << m_owner;
      end else begin
        m_elapsed++;
      end
    end else if (REQ != 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (REQ[c]) break;
      end
      m_owner = c; m_last = c; m_inflight = 1; m_elapsed = 0;
      m_write = REQ_WRITE[c];
      m_addr  = REQ_ADDR[c*ADDR_W +: ADDR_W];
      m_data  = REQ_DATA[c*DATA_W +: DATA_W];
    end
  endfunction

  task automatic compare_all();
    chk("grant",   32'(GRANT),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("menable", 32'(MENABLE),   32'(m_inflight));
    chk("ready",   32'(REQ_READY), m_ready);
    chk("err",     32'(REQ_ERR),   m_err);
    chk("rdata",   32'(RDATA),     m_rdata);
    chk("mwrite",  32'(MWRITE),    32'(m_write));
    chk("maddr",   32'(MADDR),     m_addr);
    chk("mdata",   32'(MDATA),     m_data);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_core(input int c, input bit wr, input int unsigned a, input int unsigned d);
    REQ_WRITE[c] = wr;
    REQ_ADDR[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
    REQ_DATA[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  int men_cycles;
  int err_pulses;
  int ready_pulses;
  bit hit;

  initial begin
    RESET = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_DATA = '0;
    MREADY = 1'b0; MRDATA = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all();
    RESET = 1'b0;

    // Single write from core0, PREADY three cycles after enable.
    set_core(0, 1'b1, 32'h01, 32'h3);
    REQ = 2'b01;
    tick();
    REQ = 2'b00;
    tick(); tick();
    MREADY = 1'b1;
    tick();
    MREADY = 1'b0;
    tick(); tick();

    // Both cores requesting continuously with instant completion: grants alternate.
    set_core(1, 1'b1, 32'h22, 32'h55);
    REQ = 2'b11; MREADY = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    REQ = 2'b00; MREADY = 1'b0;
    tick(); tick(); tick();

    // Core1 read, then core1 write must leave RDATA untouched.
    set_core(1, 1'b0, 32'h40, 32'h0);
    REQ = 2'b10; MREADY = 1'b1; MRDATA = 21'h1F;
    tick();
    REQ = 2'b00;
    tick(); tick();
    chk("rdata_read", 32'(RDATA), 32'h1F);
    set_core(1, 1'b1, 32'h41, 32'h7);
    REQ = 2'b10; MRDATA = 21'h1AAAA;
    tick();
    REQ = 2'b00;
    tick(); tick();
    chk("rdata_hold", 32'(RDATA), 32'h1F);
    MREADY = 1'b0;

    // Timeout: MREADY never comes.
    set_core(0, 1'b0, 32'h10, 32'h0);
    REQ = 2'b01;
    men_cycles = 0; err_pulses = 0; ready_pulses = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      REQ = 2'b00;
      if (MENABLE === 1'b1) men_cycles++;
      if (REQ_ERR[0] === 1'b1) err_pulses++;
      if (REQ_READY !== 2'b00) ready_pulses++;
    end
    chk("timeout_men_cycles", 32'(men_cycles), 32'd16);
    chk("timeout_err_pulses", 32'(err_pulses), 32'd1);
    chk("timeout_ready", 32'(ready_pulses), 32'd0);

    // Reset two cycles into BUSY drops everything asynchronously.
    REQ = 2'b10; set_core(1, 1'b1, 32'h77, 32'h99);
    tick(); tick(); tick();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_menable", 32'(MENABLE), 32'd0);
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_ready", 32'(REQ_READY | REQ_ERR), 32'd0);
    @(posedge clk); #1;
    compare_all();
    RESET = 1'b0;
    REQ = 2'b11;
    tick();
    chk("post_rst_core0", 32'(GRANT), 32'd1);
    REQ = 2'b00;
    MREADY = 1'b1; tick(); MREADY = 1'b0; tick();

    // MREADY on the timeout edge; core0 address changes mid-transfer.
    set_core(0, 1'b1, 32'hA5, 32'h12345);
    REQ = 2'b01;
    tick();
    REQ = 2'b00;
    set_core(0, 1'b1, 32'h5A, 32'h0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_inflight && m_elapsed == TIMEOUT_CYC - 1) begin
        MREADY = 1'b1;
        hit = 1;
      end
      tick();
      MREADY = 1'b0;
    end
    chk("edge_hit", 32'(hit), 32'd1);
    chk("edge_ready", 32'(REQ_READY), 32'd1);
    chk("edge_err", 32'(REQ_ERR), 32'd0);
    chk("edge_maddr", 32'(MADDR), 32'hA5);
    tick(); tick();

    // Random traffic: frequent completions, then mostly stalls to exercise timeouts.
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 400; i++) begin
        REQ       = NUM_REQ'($urandom_range(0, 3));
        REQ_WRITE = NUM_REQ'($urandom_range(0, 3));
        REQ_ADDR  = (NUM_REQ*ADDR_W)'($urandom);
        REQ_DATA  = {11'($urandom), 31'($urandom)};
        MRDATA    = DATA_W'($urandom);
        MREADY    = (seg == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
